// File: rtl/conv_3x3_channel_accum.sv
// conv_3x3_channel_accum
//
// Accumulates CHANNEL_NUM_IN single-channel partial-sum maps, arriving
// channel-major and in raster order within a channel, into one output map.
// One bias is added per output map, and the result is saturated to
// DATA_WIDTH bits.
//
// Flow: WAIT_BIAS latches the bias. ACCUM builds the running sums in acc[].
// LAST adds the final channel and streams out the finished pixels with
// 1-cycle latency.
//
// Optional build macro:
//   CONV_ACCUM_RELU_EN - clamp negative saturated results to 0 (ReLU).
//
// Ports:
//   clk           - rising-edge clock
//   reset         - asynchronous, active-low reset
//   valid_in      - pxl_in valid this cycle
//   pxl_in        - signed partial sum from the conv 3x3 core
//   valid_bias_in - bias_in valid this cycle (accepted only in WAIT_BIAS)
//   bias_in       - signed bias for the current output channel
//   pxl_out       - signed, saturated output pixel (registered)
//   valid_out     - pxl_out valid this cycle
//   frame_done    - one-cycle pulse with the last pixel of a map
//   busy          - high from bias acceptance until frame_done
module conv_3x3_channel_accum #(
  parameter int DATA_WIDTH     = 16,
  parameter int IMAGE_WIDTH    = 64,
  parameter int IMAGE_HEIGHT   = 64,
  parameter int CHANNEL_NUM_IN = 64,
  parameter int IMAGE_SIZE     = IMAGE_WIDTH * IMAGE_HEIGHT,
  parameter int ACC_WIDTH      = DATA_WIDTH + $clog2(CHANNEL_NUM_IN) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic signed [DATA_WIDTH-1:0] pxl_in,
  input  logic                         valid_bias_in,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  output logic signed [DATA_WIDTH-1:0] pxl_out,
  output logic                         valid_out,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int PIX_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int CH_W  = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST    = PIX_W'(IMAGE_SIZE - 1);
  localparam logic [CH_W-1:0]  CH_PRE_LAST =
    CH_W'((CHANNEL_NUM_IN >= 2) ? (CHANNEL_NUM_IN - 2) : 0);

  // Saturation bounds expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    WAIT_BIAS = 2'd0,
    ACCUM     = 2'd1,
    LAST      = 2'd2
  } state_t;

  function automatic logic signed [DATA_WIDTH-1:0] sat(
    input logic signed [ACC_WIDTH-1:0] x
  );
    logic signed [DATA_WIDTH-1:0] y;
    if (x > SAT_MAX)      y = SAT_MAX[DATA_WIDTH-1:0];
    else if (x < SAT_MIN) y = SAT_MIN[DATA_WIDTH-1:0];
    else                  y = x[DATA_WIDTH-1:0];
    return y;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] post_proc(
    input logic signed [ACC_WIDTH-1:0] x
  );
    logic signed [DATA_WIDTH-1:0] s;
    s = sat(x);
`ifdef CONV_ACCUM_RELU_EN
    if (s[DATA_WIDTH-1]) s = '0;
`endif
    return s;
  endfunction

  state_t                       r_state;
  logic [PIX_W-1:0]             r_pix_cnt;
  logic [CH_W-1:0]              r_ch_cnt;
  logic signed [ACC_WIDTH-1:0]  r_bias;
  logic signed [DATA_WIDTH-1:0] r_pxl_out;
  logic                         r_valid_out;
  logic                         r_frame_done;
  logic                         r_busy;

  // Partial-sum storage; no reset, channel 0 overwrites every entry.
  logic signed [ACC_WIDTH-1:0]  r_acc [IMAGE_SIZE];

  logic signed [ACC_WIDTH-1:0]  w_pxl_ext;
  logic signed [ACC_WIDTH-1:0]  w_acc_rd;
  logic signed [ACC_WIDTH-1:0]  w_base;
  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic                         w_pix_wrap;
  logic                         w_acc_we;

  assign w_pxl_ext  = {{(ACC_WIDTH-DATA_WIDTH){pxl_in[DATA_WIDTH-1]}}, pxl_in};
  assign w_acc_rd   = r_acc[r_pix_cnt];
  // ch_cnt is 0 in ACCUM for the first channel, and also in LAST when there
  // is only one input channel: in both cases the bias seeds the sum.
  assign w_base     = (r_ch_cnt == '0) ? r_bias : w_acc_rd;
  assign w_sum      = w_base + w_pxl_ext;
  assign w_pix_wrap = (r_pix_cnt == PIX_LAST);
  assign w_acc_we   = valid_in && (r_state == ACCUM);

  always_ff @(posedge clk) begin
    if (w_acc_we) r_acc[r_pix_cnt] <= w_sum;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= WAIT_BIAS;
      r_pix_cnt    <= '0;
      r_ch_cnt     <= '0;
      r_bias       <= '0;
      r_pxl_out    <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        WAIT_BIAS: begin
          // valid_in is intentionally ignored until a bias has been taken.
          if (valid_bias_in) begin
            r_bias  <= {{(ACC_WIDTH-DATA_WIDTH){bias_in[DATA_WIDTH-1]}}, bias_in};
            r_busy  <= 1'b1;
            r_state <= (CHANNEL_NUM_IN == 1) ? LAST : ACCUM;
          end
        end
        ACCUM: begin
          if (valid_in) begin
            if (w_pix_wrap) begin
              r_pix_cnt <= '0;
              r_ch_cnt  <= r_ch_cnt + CH_W'(1);
              if (r_ch_cnt == CH_PRE_LAST) r_state <= LAST;
            end else begin
              r_pix_cnt <= r_pix_cnt + PIX_W'(1);
            end
          end
        end
        LAST: begin
          if (valid_in) begin
            r_valid_out <= 1'b1;
            r_pxl_out   <= post_proc(w_sum);
            if (w_pix_wrap) begin
              r_pix_cnt    <= '0;
              r_ch_cnt     <= '0;
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= WAIT_BIAS;
            end else begin
              r_pix_cnt <= r_pix_cnt + PIX_W'(1);
            end
          end
        end
        default: r_state <= WAIT_BIAS;
      endcase
    end
  end

  assign pxl_out    = r_pxl_out;
  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_conv_3x3_channel_accum.sv
// Directed bench for conv_3x3_channel_accum with a 4x4 map and 3 input channels.
module tb_conv_3x3_channel_accum;

  localparam int DW   = 16;
  localparam int IW   = 4;
  localparam int IH   = 4;
  localparam int CH   = 3;
  localparam int NPIX = IW * IH;

`ifdef CONV_ACCUM_RELU_EN
  localparam int RELU_EXP = 0;
`else
  localparam int RELU_EXP = -47;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 valid_in = 1'b0;
  logic signed [DW-1:0] pxl_in = '0;
  logic                 valid_bias_in = 1'b0;
  logic signed [DW-1:0] bias_in = '0;
  logic signed [DW-1:0] pxl_out;
  logic                 valid_out;
  logic                 frame_done;
  logic                 busy;

  int n_err = 0;
  int n_chk = 0;

  conv_3x3_channel_accum #(
    .DATA_WIDTH    (DW),
    .IMAGE_WIDTH   (IW),
    .IMAGE_HEIGHT  (IH),
    .CHANNEL_NUM_IN(CH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .pxl_in       (pxl_in),
    .valid_bias_in(valid_bias_in),
    .bias_in      (bias_in),
    .pxl_out      (pxl_out),
    .valid_out    (valid_out),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // kind 0: channel c pixels = c+1; kind 1: pixel = p+16c (expect 3p+48);
  // kind 2: all pixels = pconst.
  task automatic run_frame(input int bias, input int kind, input int pconst,
                           input int exp_const, input bit gaps,
                           input bit extra_bias);
    int v;
    int e;
    // Bias cycle carries a stray valid_in that must be dropped.
    bias_in       = DW'(bias);
    valid_bias_in = 1'b1;
    valid_in      = 1'b1;
    pxl_in        = 16'sd7777;
    step;
    valid_bias_in = 1'b0;
    valid_in      = 1'b0;
    check("busy_rise", int'(busy), 1);
    for (int c = 0; c < CH; c++) begin
      for (int p = 0; p < NPIX; p++) begin
        if (gaps) begin
          valid_in = 1'b0;
          step;
          check("gap_vld", int'(valid_out), 0);
        end
        v = (kind == 0) ? (c + 1) : (kind == 1) ? (p + 16 * c) : pconst;
        valid_in = 1'b1;
        pxl_in   = DW'(v);
        if (extra_bias && c == 1 && p == 3) begin
          valid_bias_in = 1'b1;
          bias_in       = 16'sd999;
        end
        step;
        valid_bias_in = 1'b0;
        valid_in      = 1'b0;
        if (c == CH - 1) begin
          e = (kind == 1) ? (3 * p + 48) : exp_const;
          check("out_vld", int'(valid_out), 1);
          check("out_pxl", int'(pxl_out), e);
          check("frame_done", int'(frame_done), int'(p == NPIX - 1));
          check("busy", int'(busy), int'(p != NPIX - 1));
        end else begin
          check("acc_vld", int'(valid_out), 0);
        end
      end
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_pxl", int'(pxl_out), 0);
    check("rst_vld", int'(valid_out), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_busy", int'(busy), 0);
    step;
    step;
    reset = 1'b1;
    step;

    // Basic frame, then gapped ramp frame back-to-back
    run_frame(10, 0, 0, 16, 1'b0, 1'b0);
    run_frame(0, 1, 0, 0, 1'b1, 1'b0);

    // Saturation both ways
    run_frame(32767, 2, 100, 32767, 1'b0, 1'b0);
    run_frame(-32768, 2, -100, -32768, 1'b0, 1'b0);

    // Negative result: ReLU clamps or passes -47
    run_frame(-50, 2, 1, RELU_EXP, 1'b0, 1'b0);

    // valid_in before any bias is dropped
    step;
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1;
      pxl_in   = 16'sd500;
      step;
      check("pre_vld", int'(valid_out), 0);
      check("pre_busy", int'(busy), 0);
    end
    valid_in = 1'b0;
    run_frame(10, 0, 0, 16, 1'b0, 1'b1);

    // Consecutive frames with different biases
    run_frame(10, 0, 0, 16, 1'b0, 1'b0);
    run_frame(20, 0, 0, 26, 1'b0, 1'b0);

    // Reset during channel 1, pixel 7
    bias_in       = 16'sd10;
    valid_bias_in = 1'b1;
    step;
    valid_bias_in = 1'b0;
    for (int k = 0; k < NPIX + 7; k++) begin
      valid_in = 1'b1;
      pxl_in   = (k < NPIX) ? 16'sd1 : 16'sd2;
      step;
    end
    valid_in = 1'b1;
    pxl_in   = 16'sd2;
    reset    = 1'b0;
    #1;
    check("mrst_pxl", int'(pxl_out), 0);
    check("mrst_vld", int'(valid_out), 0);
    check("mrst_done", int'(frame_done), 0);
    check("mrst_busy", int'(busy), 0);
    valid_in = 1'b0;
    step;
    step;
    reset = 1'b1;
    step;
    run_frame(10, 0, 0, 16, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_3x3_channel_accum.md
# conv_3x3_channel_accum

Downstream stage of the per-channel 3x3 convolution top. It consumes that block's single-channel partial-sum stream, `pxl_out`/`valid_out`, and accumulates `CHANNEL_NUM_IN` partial maps pixel-by-pixel. It adds one bias per output channel and saturates the sum to `DATA_WIDTH`. It emits one finished output-channel map per frame to the next layer.

## Interface
Parameters:
- `DATA_WIDTH`, 16: signed two's-complement sample width (input, bias and output).
- `IMAGE_WIDTH`, 64: output map width.
- `IMAGE_HEIGHT`, 64: output map height.
- `CHANNEL_NUM_IN`, 64: number of partial maps summed per output map.
- `IMAGE_SIZE`, `IMAGE_WIDTH*IMAGE_HEIGHT`: pixels per map.
- `ACC_WIDTH`, `DATA_WIDTH+$clog2(CHANNEL_NUM_IN)+1`: accumulator word width.

Ports:
- `clk`, in, 1: the single clock; all logic is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `valid_in`, in, 1: `pxl_in` is valid this cycle.
- `pxl_in`, in, `DATA_WIDTH`: partial sum from the conv 3x3 core, signed.
- `valid_bias_in`, in, 1: `bias_in` is valid this cycle.
- `bias_in`, in, `DATA_WIDTH`: bias for the current output channel, signed.
- `pxl_out`, out, `DATA_WIDTH`: final accumulated pixel, signed and saturated.
- `valid_out`, out, 1: `pxl_out` is valid this cycle.
- `frame_done`, out, 1: one-cycle pulse coincident with the last pixel of a map.
- `busy`, out, 1: high from bias acceptance until `frame_done`.

## Operation
- Input order: channel-major, raster within a channel. All `IMAGE_SIZE` pixels of channel 0 arrive first, then all pixels of channel 1, and so on. `valid_in` may have arbitrary gaps.
- Storage: an accumulator array `acc[0..IMAGE_SIZE-1]` of `ACC_WIDTH` bits each. It is not reset; channel 0 overwrites every entry.
- Counters:
  - `pix_cnt` counts 0..`IMAGE_SIZE-1` and advances only on an accepted `valid_in`.
  - `ch_cnt` counts 0..`CHANNEL_NUM_IN-1` and advances when `pix_cnt` wraps.
- States:
  - `WAIT_BIAS` (reset state). On `valid_bias_in`, latch `bias_in` sign-extended to `ACC_WIDTH` and go to `ACCUM`. `valid_in` is dropped here: no counter moves and no array write happens.
  - `ACCUM`. For each accepted sample:
    - `ch_cnt==0`: `acc[pix_cnt] = bias + pxl_in`.
    - otherwise: `acc[pix_cnt] = acc[pix_cnt] + pxl_in`.
    - When `ch_cnt==CHANNEL_NUM_IN-2` and `pix_cnt` wraps, go to `LAST`. If `CHANNEL_NUM_IN==1`, `ACCUM` is skipped and `WAIT_BIAS` goes directly to `LAST`.
  - `LAST`. For each accepted sample, compute `sum = acc[pix_cnt] + pxl_in`, or `bias + pxl_in` when `CHANNEL_NUM_IN==1`. Output `sat(sum)`; the array is not written. On the sample with `pix_cnt==IMAGE_SIZE-1`, clear both counters and return to `WAIT_BIAS`.
- `valid_bias_in` outside `WAIT_BIAS` is ignored. The bias register keeps its value.
- `sat(x)`:
  - `x > 2^(DATA_WIDTH-1)-1` gives `2^(DATA_WIDTH-1)-1`.
  - `x < -2^(DATA_WIDTH-1)` gives `-2^(DATA_WIDTH-1)`.
  - otherwise `x[DATA_WIDTH-1:0]`.
- Intermediate accumulation never wraps: `ACC_WIDTH` covers the full range.

## Timing
- Reset values: `pxl_out=0`, `valid_out=0`, `frame_done=0`, `busy=0`, state `WAIT_BIAS`, `pix_cnt=0`, `ch_cnt=0`, bias register 0.
- Bias handshake: latched on the clock edge where `valid_bias_in` is high in `WAIT_BIAS`. `busy` rises the next cycle. A `valid_in` in that same cycle is dropped.
- Latency in `LAST`: 1 cycle. `pxl_out` and `valid_out` are registered from the accepted sample. `valid_out` is low on cycles with no accepted sample.
- `frame_done` is high in the same cycle as the last `valid_out` of the map. `busy` falls in that same cycle.
- Read-modify-write: each `acc` address is touched at most once per `IMAGE_SIZE` accepted samples. No forwarding is needed because `IMAGE_SIZE>=2` is required.
- Back-to-back frames: a new bias may be accepted on the cycle after the last `LAST` sample.
- Reset mid-operation: state, counters and outputs return to reset values immediately. The partial frame is abandoned. Array contents are don't-care.

## Configuration
- `CONV_ACCUM_RELU_EN` defined: a ReLU is applied after saturation. Negative results output 0; non-negative results are unchanged.
- `CONV_ACCUM_RELU_EN` undefined: the signed saturated result is output as-is.

## Test plan
Bench parameters: `IMAGE_WIDTH=4`, `IMAGE_HEIGHT=4`, `CHANNEL_NUM_IN=3`, `DATA_WIDTH=16`.

- **Basic frame.** Bias=10; channel c pixels all equal c+1, continuous `valid_in`. Expect 16 outputs of 16, each 1 cycle after its channel-2 sample, and `frame_done` on the 16th output.
- **Gaps and ordering.** Bias=0; channel c pixel p equals `p+16*c`; `valid_in` toggles every other cycle. Expect output p equal to `3p+48`, emitted in raster order with matching gaps.
- **Saturation.** Bias=32767 with all pixels 100 gives all outputs 32767. Bias=-32768 with all pixels -100 gives all outputs -32768.
- **ReLU macro.** Bias=-50, all pixels 1 (sum -47). With `CONV_ACCUM_RELU_EN` the output is 0; without it the output is -47 (`0xFFD1`).
- **Handshake guards.** 5 `valid_in` pulses before any bias are all dropped. A bias is then sent, plus a second bias during `ACCUM`. The first bias is used and the result matches the basic-frame scenario. Two consecutive frames with biases 10 and 20 give 16 and 26.
- **Reset mid-frame.** Assert `reset` low during channel 1, pixel 7. All outputs return to 0 and `busy`=0. A fresh full frame afterwards yields the correct basic-frame result.
